// File: rtl/amds_uart_tx_if.sv
// Handshake and data bundle between an ADC sample source and the AMDS UART transmitter.
// The source (master) supplies the trigger and samples; the transmitter (slave) drives the line and status.
interface amds_uart_tx_if;
    logic        start_tx;
    logic [15:0] adc_din0;
    logic [15:0] adc_din1;
    logic [15:0] adc_din2;
    logic [15:0] adc_din3;
    logic        dout;
    logic        busy;
    logic        tx_done;
    logic [15:0] counter_tx_complete;
    logic [15:0] counter_start_ignored;

    modport master (
        output start_tx, adc_din0, adc_din1, adc_din2, adc_din3,
        input  dout, busy, tx_done, counter_tx_complete, counter_start_ignored
    );

    modport slave (
        input  start_tx, adc_din0, adc_din1, adc_din2, adc_din3,
        output dout, busy, tx_done, counter_tx_complete, counter_start_ignored
    );
endinterface

// File: rtl/amds_uart_tx.sv
// AMDS ADC link transmitter: on start_tx, snapshots four 16-bit samples and sends
// 12 bytes (header, MSB, LSB per channel) as 8N1 frames on an idle-high line.
module amds_uart_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int GAP_CLKS     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    amds_uart_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = (GAP_CLKS > 0) ? GW'(GAP_CLKS - 1) : '0;
    localparam logic [3:0]    LAST_BYTE = 4'd11;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          dout_q, dout_d;
    logic          tx_done_q, tx_done_d;
    logic [15:0]   cnt_done_q, cnt_done_d;
    logic [15:0]   cnt_ign_q, cnt_ign_d;
    logic          load;
    logic          bit_end;
    logic [7:0]    cur_byte;
    logic [15:0]   din_w  [4];
    logic [15:0]   snap_w [4];

    assign din_w[0] = bus.adc_din0;
    assign din_w[1] = bus.adc_din1;
    assign din_w[2] = bus.adc_din2;
    assign din_w[3] = bus.adc_din3;

    // Samples are frozen at acceptance so input changes cannot tear a transmission.
    for (genvar gi = 0; gi < 4; gi++) begin : snap_g
        logic [15:0] word_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (load) begin
                word_q <= din_w[gi];
            end
        end
        assign snap_w[gi] = word_q;
    end

    always_comb begin
        cur_byte = 8'hFF;
        case (byte_idx_q)
            4'd0:    cur_byte = 8'h90;
            4'd1:    cur_byte = snap_w[0][15:8];
            4'd2:    cur_byte = snap_w[0][7:0];
            4'd3:    cur_byte = 8'h91;
            4'd4:    cur_byte = snap_w[1][15:8];
            4'd5:    cur_byte = snap_w[1][7:0];
            4'd6:    cur_byte = 8'h92;
            4'd7:    cur_byte = snap_w[2][15:8];
            4'd8:    cur_byte = snap_w[2][7:0];
            4'd9:    cur_byte = 8'h93;
            4'd10:   cur_byte = snap_w[3][15:8];
            4'd11:   cur_byte = snap_w[3][7:0];
            default: cur_byte = 8'hFF;
        endcase
    end

    assign bit_end = (clk_cnt_q == BIT_LAST);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        tx_done_d  = 1'b0;
        cnt_done_d = cnt_done_q;
        cnt_ign_d  = cnt_ign_q;
        load       = 1'b0;
        dout_d     = 1'b1;

        if (state_q != IDLE && bus.start_tx) begin
            cnt_ign_d = cnt_ign_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start_tx) begin
                    load       = 1'b1;
                    state_d    = START;
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = IDLE;
                        tx_done_d  = 1'b1;
                        cnt_done_d = cnt_done_q + 16'd1;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                        if (GAP_CLKS == 0) begin
                            state_d = START;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = START;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so it changes together with busy.
        case (state_d)
            START:   dout_d = 1'b0;
            DATA:    dout_d = cur_byte[bit_cnt_d];
            default: dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
            dout_q     <= 1'b1;
            tx_done_q  <= 1'b0;
            cnt_done_q <= '0;
            cnt_ign_q  <= '0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            dout_q     <= dout_d;
            tx_done_q  <= tx_done_d;
            cnt_done_q <= cnt_done_d;
            cnt_ign_q  <= cnt_ign_d;
        end
    end

    assign bus.dout                  = dout_q;
    assign bus.busy                  = (state_q != IDLE);
    assign bus.tx_done               = tx_done_q;
    assign bus.counter_tx_complete   = cnt_done_q;
    assign bus.counter_start_ignored = cnt_ign_q;
endmodule

// File: tb/tb_amds_uart_tx.sv
// Bench for amds_uart_tx: table vectors, hand-written corner sequences and random
// transmissions compared against a line-level waveform model built from the byte rules.
module tb_amds_uart_tx;
    localparam int CPB = 8;

    typedef struct packed {
        logic [63:0] words;
        logic [95:0] bytes;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start5;
    logic [15:0] din0, din1, din2, din3;

    int   checks = 0;
    int   failures = 0;
    logic samp_q [$];
    logic exp_q  [$];
    int   busy_cnt, done_cnt;
    vec_t tbl [3];

    always #5 clk = ~clk;

    amds_uart_tx_if bus0();
    amds_uart_tx_if bus5();

    assign bus0.start_tx = start0;
    assign bus0.adc_din0 = din0;
    assign bus0.adc_din1 = din1;
    assign bus0.adc_din2 = din2;
    assign bus0.adc_din3 = din3;
    assign bus5.start_tx = start5;
    assign bus5.adc_din0 = din0;
    assign bus5.adc_din1 = din1;
    assign bus5.adc_din2 = din2;
    assign bus5.adc_din3 = din3;

    amds_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    amds_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic get_out(input int d, output logic o_dout, output logic o_busy, output logic o_done,
                           output logic [15:0] o_ctc, output logic [15:0] o_csi);
        if (d == 0) begin
            o_dout = bus0.dout; o_busy = bus0.busy; o_done = bus0.tx_done;
            o_ctc = bus0.counter_tx_complete; o_csi = bus0.counter_start_ignored;
        end else begin
            o_dout = bus5.dout; o_busy = bus5.busy; o_done = bus5.tx_done;
            o_ctc = bus5.counter_tx_complete; o_csi = bus5.counter_start_ignored;
        end
    endtask

    task automatic set_din(input logic [63:0] w);
        din0 = w[63:48]; din1 = w[47:32]; din2 = w[31:16]; din3 = w[15:0];
    endtask

    task automatic start_pulse(input int d);
        if (d == 0) start0 = 1'b1; else start5 = 1'b1;
        tick();
        start0 = 1'b0;
        start5 = 1'b0;
    endtask

    // Reference line: each byte is start(0), 8 data bits LSB first, stop(1),
    // every bit CPB clocks wide, with gap idle clocks between bytes.
    task automatic build_wave(input logic [63:0] words, input int gap);
        logic [7:0]  b;
        logic [15:0] w;
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            w = words[63 - 16*(i/3) -: 16];
            case (i % 3)
                0:       b = 8'h90 + 8'(i/3);
                1:       b = w[15:8];
                default: b = w[7:0];
            endcase
            for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
            for (int j = 0; j < 8; j++)
                for (int k = 0; k < CPB; k++) exp_q.push_back(b[j]);
            for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
            if (i < 11)
                for (int k = 0; k < gap; k++) exp_q.push_back(1'b1);
        end
    endtask

    task automatic capture(input int d, input int n);
        logic o, bz, dn;
        logic [15:0] c1, c2;
        samp_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            get_out(d, o, bz, dn, c1, c2);
            samp_q.push_back(o);
            if (bz) busy_cnt++;
            if (dn) done_cnt++;
            tick();
        end
    endtask

    // Call right after acceptance; returns in the tx_done cycle.
    task automatic verify_tx(input int d, input int gap, input logic [63:0] words, input string tag);
        int mism;
        int first;
        logic o, bz, dn;
        logic [15:0] c1, c2;
        build_wave(words, gap);
        capture(d, exp_q.size());
        mism = 0;
        first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (samp_q[i] !== exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        check({tag, "_wave_mismatches"}, mism, 0);
        check({tag, "_busy_clocks"}, busy_cnt, 120*CPB + 11*gap);
        check({tag, "_early_done"}, done_cnt, 0);
        get_out(d, o, bz, dn, c1, c2);
        check({tag, "_end_busy"}, bz, 1'b0);
        check({tag, "_end_done"}, dn, 1'b1);
        check({tag, "_end_dout"}, o, 1'b1);
        $display("tx %s dut_gap=%0d words=%h bit_errors=%0d first_err=%0d done_count=%0d",
                 tag, gap, words, mism, first, c1);
    endtask

    task automatic decode(input int gap, output logic [95:0] got);
        int idx;
        got = '0;
        for (int b = 0; b < 12; b++)
            for (int j = 0; j < 8; j++) begin
                idx = b*(10*CPB + gap) + (1+j)*CPB + CPB/2;
                got[88 - 8*b + j] = samp_q[idx];
            end
    endtask

    initial begin
        logic o, bz, dn;
        logic [15:0] ctc, csi;
        logic [95:0] got;
        logic [63:0] w;
        logic [9:0]  lvl;
        int cnt;

        tbl[0] = '{words: 64'h1234_ABCD_0000_FFFF, bytes: 96'h901234_91ABCD_920000_93FFFF};
        tbl[1] = '{words: 64'h8001_7FFE_55AA_A55A, bytes: 96'h908001_917FFE_9255AA_93A55A};
        tbl[2] = '{words: 64'h0F0F_F0F0_0102_FEDC, bytes: 96'h900F0F_91F0F0_920102_93FEDC};

        rst_n = 1'b0; start0 = 1'b0; start5 = 1'b0;
        set_din(64'h0);
        repeat (3) tick();
        get_out(0, o, bz, dn, ctc, csi);
        check("rst_dout", o, 1'b1);
        check("rst_busy", bz, 1'b0);
        check("rst_done", dn, 1'b0);
        check("rst_ctc", ctc, 16'h0);
        check("rst_csi", csi, 16'h0);
        rst_n = 1'b1;
        tick();

        // Table vectors on the no-gap instance
        for (int i = 0; i < 3; i++) begin
            set_din(tbl[i].words);
            start_pulse(0);
            verify_tx(0, 0, tbl[i].words, $sformatf("table%0d", i));
            decode(0, got);
            for (int b = 0; b < 12; b++)
                check($sformatf("table%0d_byte%0d", i, b), got[95-8*b -: 8], tbl[i].bytes[95-8*b -: 8]);
            if (i == 0) begin
                lvl = {1'b1, 8'h90, 1'b0};
                cnt = 0;
                for (int k = 0; k < 10*CPB; k++)
                    if (samp_q[k] !== lvl[k/CPB]) cnt++;
                check("bit_timing_byte0", cnt, 0);
            end
            tick();
        end
        get_out(0, o, bz, dn, ctc, csi);
        check("table_ctc", ctc, 16'd3);
        check("table_done_cleared", dn, 1'b0);

        // Snapshot and ignored starts
        set_din(tbl[0].words);
        start_pulse(0);
        fork
            verify_tx(0, 0, tbl[0].words, "snapshot");
            begin
                repeat (100) tick();
                din0 = 16'h5555;
                for (int k = 0; k < 3; k++) begin
                    start0 = 1'b1;
                    tick();
                    start0 = 1'b0;
                    repeat (50) tick();
                end
            end
        join
        get_out(0, o, bz, dn, ctc, csi);
        check("snap_csi", csi, 16'd3);
        check("snap_ctc", ctc, 16'd4);
        capture(0, 100);
        check("snap_no_retx", busy_cnt, 0);

        // Gap instance, back-to-back with start in the tx_done cycle
        w = 64'hC3A5_0F1E_7788_0102;
        set_din(w);
        start_pulse(5);
        verify_tx(5, 5, w, "gap_first");
        cnt = 0;
        for (int k = 10*CPB; k < 10*CPB + 5; k++) cnt += int'(samp_q[k]);
        check("gap_idle_ones", cnt, 5);
        check("gap_next_start", samp_q[10*CPB + 5], 1'b0);
        w = 64'h1122_3344_5566_7788;
        set_din(w);
        start_pulse(5);
        get_out(5, o, bz, dn, ctc, csi);
        check("b2b_start_bit", o, 1'b0);
        check("b2b_busy", bz, 1'b1);
        verify_tx(5, 5, w, "gap_second");
        get_out(5, o, bz, dn, ctc, csi);
        check("gap_ctc", ctc, 16'd2);
        tick();

        // Reset during the DATA bits of byte 4
        set_din(tbl[1].words);
        start_pulse(0);
        repeat (340) tick();
        get_out(0, o, bz, dn, ctc, csi);
        check("prerst_busy", bz, 1'b1);
        rst_n = 1'b0;
        start0 = 1'b1;
        tick();
        rst_n = 1'b1;
        start0 = 1'b0;
        get_out(0, o, bz, dn, ctc, csi);
        check("mid_rst_dout", o, 1'b1);
        check("mid_rst_busy", bz, 1'b0);
        check("mid_rst_done", dn, 1'b0);
        check("mid_rst_ctc", ctc, 16'd0);
        check("mid_rst_csi", csi, 16'd0);
        get_out(5, o, bz, dn, ctc, csi);
        check("mid_rst_ctc_gapdut", ctc, 16'd0);
        capture(0, 30);
        check("post_rst_done", done_cnt, 0);
        check("post_rst_idle", busy_cnt, 0);
        set_din(tbl[2].words);
        start_pulse(0);
        verify_tx(0, 0, tbl[2].words, "after_reset");
        get_out(0, o, bz, dn, ctc, csi);
        check("after_reset_ctc", ctc, 16'd1);
        tick();

        // Random transmissions against the waveform model
        for (int r = 0; r < 20; r++) begin
            int d;
            d = (r < 15) ? 0 : 5;
            w = {$urandom(), $urandom()};
            set_din(w);
            start_pulse(d);
            verify_tx(d, (d == 0) ? 0 : 5, w, $sformatf("rand%0d", r));
            tick();
        end
        get_out(0, o, bz, dn, ctc, csi);
        check("final_ctc_gap0", ctc, 16'd16);
        check("final_csi_gap0", csi, 16'd0);
        get_out(5, o, bz, dn, ctc, csi);
        check("final_ctc_gap5", ctc, 16'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
